// File: rtl/blk_mm_pkg.sv
// Shared types and constants for the block matrix-multiply datapath.
// The helper composes row-major tile-buffer addresses from row/col counters.
package blk_mm_pkg;

  localparam int DEF_BLK_DIM = 4;
  localparam int DEF_MAC_LAT = 2;
  localparam int BIT_WIDTH   = 16;
  localparam int FRAC_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Payload carried alongside each operand read until it reaches the accumulator.
  typedef struct packed {
    logic vld;
    logic first;
  } mac_ctl_t;

  // Caller truncates the result to its own address width.
  function automatic logic [31:0] addr_compose(input logic [15:0] row,
                                               input logic [15:0] col,
                                               input int          cnt_w);
    return (32'(row) << cnt_w) | 32'(col);
  endfunction

endpackage

// File: rtl/blk_mac_seq_if.sv
// Tile-buffer read / accumulator control / result handshake bundle.
// The sequencer is the master; buffers and result writer sit on the slave side.
interface blk_mac_seq_if #(
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              acc_en;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output rd_en, a_addr, b_addr, acc_en, acc_clr, out_valid, out_addr,
    input  out_ready
  );

  modport slave (
    input  rd_en, a_addr, b_addr, acc_en, acc_clr, out_valid, out_addr,
    output out_ready
  );
endinterface

// File: rtl/mac_ctl_pipe.sv
// LAT-deep delay line for the {valid, first} control pair, matching the
// operand read-to-product latency; clr flushes every stage synchronously.
module mac_ctl_pipe
  import blk_mm_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic     clk,
  input  logic     clr,
  input  mac_ctl_t din,
  output mac_ctl_t dout
);

  mac_ctl_t [LAT:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int s = 2; s <= LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign dout = vld_pipe[LAT];

endmodule

// File: rtl/blk_mac_seq.sv
// Sequencer for one BLK_DIM x BLK_DIM output tile: issues the k-loop reads per
// element, waits out the MAC latency, then hands the element address to the result buffer.
module blk_mac_seq
  import blk_mm_pkg::*;
#(
  parameter int BLK_DIM = DEF_BLK_DIM,
  parameter int CNT_W   = $clog2(BLK_DIM),
  parameter int ADDR_W  = 2*CNT_W,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  blk_mac_seq_if.master bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_DIM - 1);
  localparam int               DW   = $clog2(MAC_LAT + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  i, j, k;
  logic [DW-1:0]     dcnt;
  logic              rd_en, out_valid;
  logic [ADDR_W-1:0] a_addr, b_addr, out_addr;
  mac_ctl_t          ctl_in, ctl_out;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (k == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dcnt == '0) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        out_valid = 1'b1;
        if (bus.out_ready)
          state_d = (i == LAST && j == LAST) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters advance with the FSM; all wraps are natural power-of-two rollovers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i    <= '0;
      j    <= '0;
      k    <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        ST_ISSUE: begin
          k <= k + 1'b1;
          if (k == LAST) dcnt <= DW'(MAC_LAT - 1);
        end
        ST_DRAIN: begin
          if (dcnt != '0) dcnt <= dcnt - 1'b1;
        end
        ST_WRITE: begin
          if (bus.out_ready) begin
            j <= j + 1'b1;
            if (j == LAST) i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_addr   = ADDR_W'(addr_compose(16'(i), 16'(k), CNT_W));
  assign b_addr   = ADDR_W'(addr_compose(16'(k), 16'(j), CNT_W));
  assign out_addr = ADDR_W'(addr_compose(16'(i), 16'(j), CNT_W));

  // The first-k flag rides with the read so the accumulator loads rather than adds.
  assign ctl_in.vld   = rd_en;
  assign ctl_in.first = (k == '0);

  mac_ctl_pipe #(.LAT(MAC_LAT)) u_ctl_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (ctl_in),
    .dout (ctl_out)
  );

  assign bus.rd_en     = rd_en;
  assign bus.a_addr    = a_addr;
  assign bus.b_addr    = b_addr;
  assign bus.acc_en    = ctl_out.vld;
  assign bus.acc_clr   = ctl_out.vld & ctl_out.first;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;

endmodule

// File: tb/tb_blk_mac_seq.sv
// Directed bench for blk_mac_seq at default parameters (BLK_DIM=4, MAC_LAT=2).
module tb_blk_mac_seq;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  blk_mac_seq_if #(.ADDR_W(4)) bus ();

  blk_mac_seq #(.BLK_DIM(4), .MAC_LAT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit busy;
    bit rd_en;
    bit acc_en;
    bit acc_clr;
    bit out_valid;
    bit chk_ab;
    int a_addr;
    int b_addr;
    int out_addr;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(bit b, bit r, bit ae, bit ac, bit v, bit ab,
                              int a, int bb, int o);
    vec_t x;
    x.busy = b; x.rd_en = r; x.acc_en = ae; x.acc_clr = ac; x.out_valid = v;
    x.chk_ab = ab; x.a_addr = a; x.b_addr = bb; x.out_addr = o;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_row(input int c);
    vec_t e;
    e = tbl[c-1];
    chk($sformatf("c%0d_busy", c),      int'(busy),          int'(e.busy));
    chk($sformatf("c%0d_rd_en", c),     int'(bus.rd_en),     int'(e.rd_en));
    chk($sformatf("c%0d_acc_en", c),    int'(bus.acc_en),    int'(e.acc_en));
    chk($sformatf("c%0d_acc_clr", c),   int'(bus.acc_clr),   int'(e.acc_clr));
    chk($sformatf("c%0d_out_valid", c), int'(bus.out_valid), int'(e.out_valid));
    chk($sformatf("c%0d_out_addr", c),  int'(bus.out_addr),  e.out_addr);
    if (e.chk_ab) begin
      chk($sformatf("c%0d_a_addr", c), int'(bus.a_addr), e.a_addr);
      chk($sformatf("c%0d_b_addr", c), int'(bus.b_addr), e.b_addr);
    end
  endtask

  // Runs one tile from IDLE. Cycle c is the cycle after the c-th edge counted
  // from the edge that samples start; outputs are read on the falling edge.
  task automatic run_tile(input string tag, input bit use_table,
                          input int stall_elem, input int stall_len,
                          input int extra_start);
    int  cyc = 0, n_hs = 0, n_done = 0, done_cyc = -1, n_acc = 0, n_clr = 0;
    int  stall_left, stall_seen = 0, order_err = 0, stall_rd = 0;
    int  stall_addr_err = 0, resume_cyc = -1;
    bit  fin = 1'b0;
    stall_left = stall_len;
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_start);
      if (use_table && cyc <= 8) check_row(cyc);
      if (resume_cyc >= 0 && cyc == resume_cyc + 1) begin
        chk({tag, "_resume_rd_en"}, int'(bus.rd_en), 1);
        chk({tag, "_resume_a_addr"}, int'(bus.a_addr), 4);
        chk({tag, "_resume_b_addr"}, int'(bus.b_addr), 3);
      end
      n_acc += int'(bus.acc_en);
      n_clr += int'(bus.acc_clr);
      if (n_done > 0 && cyc == done_cyc + 1) begin
        chk({tag, "_busy_after_done"}, int'(busy), 0);
        fin = 1'b1;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.out_valid) begin
        if (n_hs == stall_elem && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
          stall_seen++;
          if (int'(bus.out_addr) != stall_elem) stall_addr_err++;
          if (bus.rd_en) stall_rd++;
        end else begin
          bus.out_ready = 1'b1;
          if (int'(bus.out_addr) != n_hs) order_err++;
          if (n_hs == stall_elem && stall_len > 0) resume_cyc = cyc;
          n_hs++;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    chk({tag, "_finished"},   int'(fin), 1);
    chk({tag, "_handshakes"}, n_hs, 16);
    chk({tag, "_order_err"},  order_err, 0);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_done_cycle"}, done_cyc, 113 + stall_len);
    chk({tag, "_acc_en_cnt"}, n_acc, 64);
    chk({tag, "_acc_clr_cnt"}, n_clr, 16);
    if (stall_len > 0) begin
      chk({tag, "_stall_cycles"}, stall_seen, stall_len);
      chk({tag, "_stall_addr"},   stall_addr_err, 0);
      chk({tag, "_stall_rd_en"},  stall_rd, 0);
    end
    repeat (4) @(negedge clk);
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    int quiet;
    tbl[0] = mk(1, 1, 0, 0, 0, 1, 0,  0, 0);
    tbl[1] = mk(1, 1, 0, 0, 0, 1, 1,  4, 0);
    tbl[2] = mk(1, 1, 1, 1, 0, 1, 2,  8, 0);
    tbl[3] = mk(1, 1, 1, 0, 0, 1, 3, 12, 0);
    tbl[4] = mk(1, 0, 1, 0, 0, 0, 0,  0, 0);
    tbl[5] = mk(1, 0, 1, 0, 0, 0, 0,  0, 0);
    tbl[6] = mk(1, 0, 0, 0, 1, 0, 0,  0, 0);
    tbl[7] = mk(1, 1, 0, 0, 0, 1, 0,  1, 1);

    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",      int'(busy),          0);
    chk("rst_done",      int'(done),          0);
    chk("rst_rd_en",     int'(bus.rd_en),     0);
    chk("rst_acc_en",    int'(bus.acc_en),    0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_addr",  int'(bus.out_addr),  0);
    rst = 1'b0;

    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      bus.out_ready = 1'($urandom_range(0, 1));
      quiet += int'(busy) + int'(done) + int'(bus.rd_en) + int'(bus.acc_en)
             + int'(bus.out_valid);
    end
    chk("idle_quiet", quiet, 0);

    run_tile("tile",  1'b1, -1, 0, -1);
    run_tile("stall", 1'b0,  6, 5, -1);
    run_tile("busy_start", 1'b0, -1, 0, 30);

    // Reset while element (0,1) is issuing k=2.
    @(negedge clk);
    start = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_rd_en",  int'(bus.rd_en),  1);
    chk("mid_a_addr", int'(bus.a_addr), 2);
    chk("mid_b_addr", int'(bus.b_addr), 9);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",      int'(busy),          0);
    chk("abort_done",      int'(done),          0);
    chk("abort_rd_en",     int'(bus.rd_en),     0);
    chk("abort_acc_en",    int'(bus.acc_en),    0);
    chk("abort_acc_clr",   int'(bus.acc_clr),   0);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_out_addr",  int'(bus.out_addr),  0);
    chk("abort_a_addr",    int'(bus.a_addr),    0);
    chk("abort_b_addr",    int'(bus.b_addr),    0);
    rst = 1'b0;
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      quiet += int'(bus.acc_en) + int'(bus.out_valid) + int'(busy);
    end
    chk("abort_quiet", quiet, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/blk_mac_seq.md
Name: blk_mac_seq

Overview:
- Sequencer for one BLK_DIM x BLK_DIM tile of the block matrix multiply.
- Computes every output element C[i][j] = saturate(sum over k of A[i][k]*B[k][j]).
- Drives the A/B tile-buffer read addresses and the accumulator load/add controls.
- Presents each finished element address to the result buffer, with a valid/ready handshake, once the saturating narrow-down stage's input is final.

Parameters:
- BLK_DIM, 4: tile edge; power of two, >= 2.
- CNT_W, $clog2(BLK_DIM): width of the i/j/k counters.
- ADDR_W, 2*CNT_W: tile-buffer address width (row-major, addr = row*BLK_DIM + col).
- MAC_LAT, 2: cycles from rd_en to the operand product arriving at the accumulator input; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a tile; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last element is accepted
- rd_en  out  1  A/B buffer read strobe
- a_addr  out  ADDR_W  A buffer address = i*BLK_DIM + k
- b_addr  out  ADDR_W  B buffer address = k*BLK_DIM + j
- acc_en  out  1  accumulator update strobe
- acc_clr  out  1  with acc_en: load the product instead of adding it
- out_valid  out  1  accumulator (post-saturate) holds element (i,j)
- out_ready  in  1  result buffer accepts the element
- out_addr  out  ADDR_W  result address = i*BLK_DIM + j

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, i=j=k=0, delay pipe cleared, all outputs 0.
- Reset mid-operation: abort at the next edge; no acc_en or out_valid is issued afterwards.
- FSM: IDLE -> ISSUE -> DRAIN -> WRITE -> (ISSUE | DONE) -> IDLE.
- IDLE: start=1 moves to ISSUE with i=j=k=0.
- ISSUE: one cycle per k, k = 0..BLK_DIM-1.
  - rd_en=1; a_addr and b_addr are combinational from i, j, k.
  - At k=BLK_DIM-1: k<=0, go to DRAIN.
- Delay line: MAC_LAT-stage shift register carrying {rd_en, k==0}.
  - Output stage drives acc_en and acc_clr (acc_clr = first-flag AND valid).
  - acc_en for a read issued in cycle t rises in cycle t+MAC_LAT.
- DRAIN: exactly MAC_LAT cycles (down-counter), rd_en=0. The last acc_en coincides with the final DRAIN cycle.
- WRITE: out_valid=1, out_addr=i*BLK_DIM+j.
  - out_valid and out_addr stay stable until out_ready=1.
  - On the handshake, advance j; on j wrap, advance i.
  - Go to ISSUE, or to DONE when i=j=BLK_DIM-1.
  - out_ready while out_valid=0 is ignored.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE.
- start while busy is ignored; it is not queued.
- Zero-backpressure cost per element: BLK_DIM + MAC_LAT + 1 cycles.
  - Default parameters: 7 cycles per element, 112 cycles per tile, then 1 DONE cycle.
- No overlap between elements: issue for (i,j+1) starts only after the (i,j) handshake, so the accumulator is never shared.
- Counter wrap: all counters are natural CNT_W-bit wraps at BLK_DIM-1. No arithmetic overflow is possible.

Decomposition:
- Shared package blk_mm_pkg:
  - state enum (IDLE, ISSUE, DRAIN, WRITE, DONE).
  - Default constants BLK_DIM, MAC_LAT, BIT_WIDTH=16, FRAC_WIDTH=8.
  - Address-compose helper.
- One sub-module, mac_ctl_pipe: parameterised MAC_LAT-deep, 2-bit shift register with synchronous active-high clear.

Test Plan:
- Reset then idle: start=0 for 20 cycles -> busy, done, rd_en, acc_en and out_valid all stay 0.
- Single element, defaults, out_ready=1:
  - start pulse -> rd_en high 4 cycles, a_addr 0,1,2,3 and b_addr 0,4,8,12.
  - acc_en high exactly 2 cycles later, acc_clr only on its first cycle.
  - out_valid at cycle 7 with out_addr=0.
- Full tile, out_ready=1: 16 handshakes, out_addr 0..15 in order; done pulses once at cycle 113 after start; busy falls the next cycle.
- Backpressure: out_ready=0 for 5 cycles at element (1,2) -> out_valid held with out_addr=6, no rd_en during the stall; element (1,3) issues the cycle after acceptance.
- Reset mid-ISSUE: assert rst during element (0,1), k=2 -> next cycle all outputs 0, and no acc_en in the following MAC_LAT cycles.
- start during busy: pulse start at cycle 30 -> no effect; exactly 16 elements and one done.
